// File: rtl/ddr_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-command DDR controller port.
// One command is in flight at a time: IDLE -> BUSY (command on the bus) -> DONE (ready pulse) -> IDLE.
module ddr_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req0_rw,
  input  logic [27:0]  req0_addr,
  input  logic [255:0] req0_wdata,
  output logic         req0_ready,
  output logic [255:0] req0_rdata,
  input  logic         req1_valid,
  input  logic         req1_rw,
  input  logic [27:0]  req1_addr,
  input  logic [255:0] req1_wdata,
  output logic         req1_ready,
  output logic [255:0] req1_rdata,
  output logic         mem_valid_data,
  output logic         mem_rw_data,
  output logic [27:0]  mem_data_addr,
  output logic [255:0] mem_data_wr,
  input  logic [255:0] mem_data_rd,
  input  logic         mem_ready_data,
  output logic         busy,
  output logic         err_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_q, grant_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           mem_valid_q, mem_valid_d;
  logic           mem_rw_q, mem_rw_d;
  logic [27:0]    mem_addr_q, mem_addr_d;
  logic [255:0]   mem_wr_q, mem_wr_d;
  logic           ready0_q, ready0_d;
  logic           ready1_q, ready1_d;
  logic [255:0]   rdata0_q, rdata0_d;
  logic [255:0]   rdata1_q, rdata1_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           win;

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_rw_d     = mem_rw_q;
    mem_addr_d   = mem_addr_q;
    mem_wr_d     = mem_wr_q;
    ready0_d     = ready0_q;
    ready1_d     = ready1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    err_d        = err_q;
    win          = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester that was not served last wins.
          win         = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          grant_d     = win;
          mem_rw_d    = win ? req1_rw    : req0_rw;
          mem_addr_d  = win ? req1_addr  : req0_addr;
          mem_wr_d    = win ? req1_wdata : req0_wdata;
          mem_valid_d = 1'b1;
          cnt_d       = 16'd0;
          state_d     = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready_data) begin
          mem_valid_d  = 1'b0;
          last_grant_d = grant_q;
          state_d      = DONE;
          if (grant_q) begin
            ready1_d = 1'b1;
            if (!mem_rw_q) begin
              rdata1_d = mem_data_rd;
            end else begin
              rdata1_d = rdata1_q;
            end
          end else begin
            ready0_d = 1'b1;
            if (!mem_rw_q) begin
              rdata0_d = mem_data_rd;
            end else begin
              rdata0_d = rdata0_q;
            end
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Abandon the command: requester is released, read data left untouched.
          mem_valid_d  = 1'b0;
          err_d        = 1'b1;
          last_grant_d = grant_q;
          state_d      = DONE;
          if (grant_q) begin
            ready1_d = 1'b1;
          end else begin
            ready0_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        ready0_d = 1'b0;
        ready1_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        ready0_d    = 1'b0;
        ready1_d    = 1'b0;
      end
    endcase

    busy_d = (state_d == BUSY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= 16'd0;
      mem_valid_q  <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= 28'd0;
      mem_wr_q     <= 256'd0;
      ready0_q     <= 1'b0;
      ready1_q     <= 1'b0;
      rdata0_q     <= 256'd0;
      rdata1_q     <= 256'd0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wr_q     <= mem_wr_d;
      ready0_q     <= ready0_d;
      ready1_q     <= ready1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign req0_ready     = ready0_q;
  assign req1_ready     = ready1_q;
  assign req0_rdata     = rdata0_q;
  assign req1_rdata     = rdata1_q;
  assign mem_valid_data = mem_valid_q;
  assign mem_rw_data    = mem_rw_q;
  assign mem_data_addr  = mem_addr_q;
  assign mem_data_wr    = mem_wr_q;
  assign busy           = busy_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: a per-cycle vector table followed by
// hand-written timeout, reset-in-flight and ready-vs-timeout sequences.
module tb_ddr_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_rw, req1_valid, req1_rw;
  logic [27:0]  req0_addr, req1_addr;
  logic [255:0] req0_wdata, req1_wdata;
  logic         req0_ready, req1_ready;
  logic [255:0] req0_rdata, req1_rdata;
  logic         mem_valid_data, mem_rw_data, mem_ready_data;
  logic [27:0]  mem_data_addr;
  logic [255:0] mem_data_wr, mem_data_rd;
  logic         busy, err_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .mem_valid_data(mem_valid_data), .mem_rw_data(mem_rw_data), .mem_data_addr(mem_data_addr),
    .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd), .mem_ready_data(mem_ready_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    string        name;
    logic         rst, v0, rw0;
    logic [27:0]  a0;
    logic [255:0] w0;
    logic         v1, rw1;
    logic [27:0]  a1;
    logic [255:0] w1;
    logic         mr;
    logic [255:0] mrd;
    logic         e_mv, e_mrw;
    logic [27:0]  e_addr;
    logic [255:0] e_wd;
    logic         e_r0, e_r1;
    logic [255:0] e_rd0, e_rd1;
    logic         e_busy, e_err;
  } vec_t;

  vec_t vecs[$];

  localparam logic [27:0]  Z28  = 28'h0;
  localparam logic [255:0] Z    = 256'h0;
  localparam logic [27:0]  A_A  = 28'h1000000;
  localparam logic [255:0] W_A5 = 256'hA5;
  localparam logic [27:0]  A_X  = 28'h0ABCDEF;
  localparam logic [255:0] W_X  = 256'h55;
  localparam logic [27:0]  A0B  = 28'h0000111;
  localparam logic [255:0] W0B  = 256'h11;
  localparam logic [27:0]  A1B  = 28'h0000222;
  localparam logic [255:0] W1B  = 256'h22;
  localparam logic [255:0] DEAD = 256'hDEAD;
  localparam logic [255:0] BEEF = 256'hBEEF;
  localparam logic [255:0] D77  = 256'h77;

  task automatic row(input string nm, input logic r, input logic v0, input logic rw0, input logic [27:0] a0,
                     input logic [255:0] w0, input logic v1, input logic rw1, input logic [27:0] a1,
                     input logic [255:0] w1, input logic mr, input logic [255:0] mrd,
                     input logic e_mv, input logic e_mrw, input logic [27:0] e_addr, input logic [255:0] e_wd,
                     input logic e_r0, input logic e_r1, input logic [255:0] e_rd0, input logic [255:0] e_rd1,
                     input logic e_busy, input logic e_err);
    vec_t v;
    v.name = nm; v.rst = r; v.v0 = v0; v.rw0 = rw0; v.a0 = a0; v.w0 = w0;
    v.v1 = v1; v.rw1 = rw1; v.a1 = a1; v.w1 = w1; v.mr = mr; v.mrd = mrd;
    v.e_mv = e_mv; v.e_mrw = e_mrw; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
    v.e_busy = e_busy; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = Z28; req0_wdata = Z;
    req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = Z28; req1_wdata = Z;
    mem_ready_data = 1'b0; mem_data_rd = Z;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    //   name       rst   v0    rw0   a0    w0    v1    rw1   a1    w1    mr    mrd   | mv  mrw  addr  wd    r0    r1    rd0  rd1   busy  err
    row("rst",      1'b1, 1'b0, 1'b0, Z28,  Z,    1'b0, 1'b0, Z28,  Z,    1'b0, Z,    1'b0, 1'b0, Z28, Z,    1'b0, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("a_grant",  1'b0, 1'b1, 1'b1, A_A,  W_A5, 1'b0, 1'b0, Z28,  Z,    1'b0, Z,    1'b1, 1'b1, A_A, W_A5, 1'b0, 1'b0, Z,   Z,    1'b1, 1'b0);
    row("a_busy1",  1'b0, 1'b1, 1'b0, A_X,  W_X,  1'b0, 1'b0, Z28,  Z,    1'b0, Z,    1'b1, 1'b1, A_A, W_A5, 1'b0, 1'b0, Z,   Z,    1'b1, 1'b0);
    row("a_busy2",  1'b0, 1'b1, 1'b0, A_X,  W_X,  1'b1, 1'b0, A_X,  W_X,  1'b0, Z,    1'b1, 1'b1, A_A, W_A5, 1'b0, 1'b0, Z,   Z,    1'b1, 1'b0);
    row("a_done",   1'b0, 1'b1, 1'b1, A_A,  W_A5, 1'b0, 1'b0, Z28,  Z,    1'b1, DEAD, 1'b0, 1'b1, A_A, W_A5, 1'b1, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("a_hold",   1'b0, 1'b1, 1'b1, A_A,  W_A5, 1'b0, 1'b0, Z28,  Z,    1'b0, Z,    1'b0, 1'b1, A_A, W_A5, 1'b0, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("a_idle",   1'b0, 1'b0, 1'b1, A_A,  W_A5, 1'b0, 1'b0, Z28,  Z,    1'b0, Z,    1'b0, 1'b1, A_A, W_A5, 1'b0, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("b_rst",    1'b1, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b0, Z28, Z,    1'b0, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("b_g0",     1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b1, 1'b1, A0B, W0B,  1'b0, 1'b0, Z,   Z,    1'b1, 1'b0);
    row("b_d0",     1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b1, A0B, W0B,  1'b1, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("b_i0",     1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b1, A0B, W0B,  1'b0, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("b_g1",     1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b1, 1'b1, A1B, W1B,  1'b0, 1'b0, Z,   Z,    1'b1, 1'b0);
    row("b_d1",     1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b1, A1B, W1B,  1'b0, 1'b1, Z,   Z,    1'b0, 1'b0);
    row("b_i1",     1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b1, A1B, W1B,  1'b0, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("b_g0b",    1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b1, 1'b1, A0B, W0B,  1'b0, 1'b0, Z,   Z,    1'b1, 1'b0);
    row("b_d0b",    1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b1, A0B, W0B,  1'b1, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("b_i0b",    1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b1, A0B, W0B,  1'b0, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("b_g1b",    1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b1, 1'b1, A1B, W1B,  1'b0, 1'b0, Z,   Z,    1'b1, 1'b0);
    row("b_d1b",    1'b0, 1'b1, 1'b1, A0B,  W0B,  1'b1, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b1, A1B, W1B,  1'b0, 1'b1, Z,   Z,    1'b0, 1'b0);
    row("b_i1b",    1'b0, 1'b0, 1'b1, A0B,  W0B,  1'b0, 1'b1, A1B,  W1B,  1'b1, Z,    1'b0, 1'b1, A1B, W1B,  1'b0, 1'b0, Z,   Z,    1'b0, 1'b0);
    row("c_rg1",    1'b0, 1'b0, 1'b0, Z28,  Z,    1'b1, 1'b0, 28'h0000040, Z, 1'b0, Z, 1'b1, 1'b0, 28'h0000040, Z, 1'b0, 1'b0, Z, Z,   1'b1, 1'b0);
    row("c_rd1",    1'b0, 1'b0, 1'b0, Z28,  Z,    1'b1, 1'b0, 28'h0000040, Z, 1'b1, DEAD, 1'b0, 1'b0, 28'h0000040, Z, 1'b0, 1'b1, Z, DEAD, 1'b0, 1'b0);
    row("c_ri1",    1'b0, 1'b0, 1'b0, Z28,  Z,    1'b0, 1'b0, 28'h0000040, Z, 1'b0, DEAD, 1'b0, 1'b0, 28'h0000040, Z, 1'b0, 1'b0, Z, DEAD, 1'b0, 1'b0);
    row("c_wg1",    1'b0, 1'b0, 1'b0, Z28,  Z,    1'b1, 1'b1, 28'h0000080, BEEF, 1'b0, Z, 1'b1, 1'b1, 28'h0000080, BEEF, 1'b0, 1'b0, Z, DEAD, 1'b1, 1'b0);
    row("c_wd1",    1'b0, 1'b0, 1'b0, Z28,  Z,    1'b1, 1'b1, 28'h0000080, BEEF, 1'b1, 256'h1234, 1'b0, 1'b1, 28'h0000080, BEEF, 1'b0, 1'b1, Z, DEAD, 1'b0, 1'b0);
    row("c_wi1",    1'b0, 1'b0, 1'b0, Z28,  Z,    1'b0, 1'b1, 28'h0000080, BEEF, 1'b0, Z, 1'b0, 1'b1, 28'h0000080, BEEF, 1'b0, 1'b0, Z, DEAD, 1'b0, 1'b0);
    row("c_rg0",    1'b0, 1'b1, 1'b0, 28'h0000020, Z, 1'b0, 1'b0, Z28, Z, 1'b0, Z,    1'b1, 1'b0, 28'h0000020, Z, 1'b0, 1'b0, Z, DEAD,   1'b1, 1'b0);
    row("c_rd0",    1'b0, 1'b1, 1'b0, 28'h0000020, Z, 1'b0, 1'b0, Z28, Z, 1'b1, D77,  1'b0, 1'b0, 28'h0000020, Z, 1'b1, 1'b0, D77, DEAD, 1'b0, 1'b0);
    row("c_ri0",    1'b0, 1'b0, 1'b0, 28'h0000020, Z, 1'b0, 1'b0, Z28, Z, 1'b0, Z,    1'b0, 1'b0, 28'h0000020, Z, 1'b0, 1'b0, D77, DEAD, 1'b0, 1'b0);
    row("d_mr1",    1'b0, 1'b0, 1'b0, Z28,  Z,    1'b0, 1'b0, Z28,  Z,    1'b1, 256'h99, 1'b0, 1'b0, 28'h0000020, Z, 1'b0, 1'b0, D77, DEAD, 1'b0, 1'b0);
    row("d_mr2",    1'b0, 1'b0, 1'b0, Z28,  Z,    1'b0, 1'b0, Z28,  Z,    1'b1, 256'h99, 1'b0, 1'b0, 28'h0000020, Z, 1'b0, 1'b0, D77, DEAD, 1'b0, 1'b0);
    row("d_idle",   1'b0, 1'b0, 1'b0, Z28,  Z,    1'b0, 1'b0, Z28,  Z,    1'b0, Z,    1'b0, 1'b0, 28'h0000020, Z, 1'b0, 1'b0, D77, DEAD, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req0_valid = vecs[i].v0; req0_rw = vecs[i].rw0; req0_addr = vecs[i].a0; req0_wdata = vecs[i].w0;
      req1_valid = vecs[i].v1; req1_rw = vecs[i].rw1; req1_addr = vecs[i].a1; req1_wdata = vecs[i].w1;
      mem_ready_data = vecs[i].mr; mem_data_rd = vecs[i].mrd;
      tick();
      chk({vecs[i].name, ".mem_valid"}, {255'd0, mem_valid_data}, {255'd0, vecs[i].e_mv});
      chk({vecs[i].name, ".mem_rw"},    {255'd0, mem_rw_data},    {255'd0, vecs[i].e_mrw});
      chk({vecs[i].name, ".mem_addr"},  {228'd0, mem_data_addr},  {228'd0, vecs[i].e_addr});
      chk({vecs[i].name, ".mem_wr"},    mem_data_wr,              vecs[i].e_wd);
      chk({vecs[i].name, ".req0_ready"}, {255'd0, req0_ready},    {255'd0, vecs[i].e_r0});
      chk({vecs[i].name, ".req1_ready"}, {255'd0, req1_ready},    {255'd0, vecs[i].e_r1});
      chk({vecs[i].name, ".req0_rdata"}, req0_rdata,              vecs[i].e_rd0);
      chk({vecs[i].name, ".req1_rdata"}, req1_rdata,              vecs[i].e_rd1);
      chk({vecs[i].name, ".busy"},       {255'd0, busy},          {255'd0, vecs[i].e_busy});
      chk({vecs[i].name, ".err"},        {255'd0, err_timeout},   {255'd0, vecs[i].e_err});
    end

    // Timeout: req0 read never answered, abandoned after 8 BUSY cycles.
    idle_inputs();
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 28'h0000300; mem_data_rd = 256'hBAD;
    tick();
    chk("to_enter.mem_valid", {255'd0, mem_valid_data}, {255'd0, 1'b1});
    chk("to_enter.busy", {255'd0, busy}, {255'd0, 1'b1});
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_wait%0d.mem_valid", i), {255'd0, mem_valid_data}, {255'd0, 1'b1});
      chk($sformatf("to_wait%0d.req0_ready", i), {255'd0, req0_ready}, {255'd0, 1'b0});
      chk($sformatf("to_wait%0d.err", i), {255'd0, err_timeout}, {255'd0, 1'b0});
    end
    tick();
    chk("to_fire.mem_valid", {255'd0, mem_valid_data}, {255'd0, 1'b0});
    chk("to_fire.err", {255'd0, err_timeout}, {255'd0, 1'b1});
    chk("to_fire.req0_ready", {255'd0, req0_ready}, {255'd0, 1'b1});
    chk("to_fire.req1_ready", {255'd0, req1_ready}, {255'd0, 1'b0});
    chk("to_fire.req0_rdata", req0_rdata, D77);
    chk("to_fire.busy", {255'd0, busy}, {255'd0, 1'b0});
    req0_valid = 1'b0;
    tick();
    chk("to_after.req0_ready", {255'd0, req0_ready}, {255'd0, 1'b0});
    chk("to_after.err", {255'd0, err_timeout}, {255'd0, 1'b1});
    tick();
    chk("to_sticky.err", {255'd0, err_timeout}, {255'd0, 1'b1});

    // Reset arriving in the second BUSY cycle discards the transfer.
    req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 28'h0000444; req1_wdata = 256'h44;
    tick();
    chk("rb_enter.busy", {255'd0, busy}, {255'd0, 1'b1});
    chk("rb_enter.mem_addr", {228'd0, mem_data_addr}, {228'd0, 28'h0000444});
    tick();
    rst = 1'b1; mem_ready_data = 1'b1;
    tick();
    chk("rb_rst.mem_valid", {255'd0, mem_valid_data}, {255'd0, 1'b0});
    chk("rb_rst.mem_rw", {255'd0, mem_rw_data}, {255'd0, 1'b0});
    chk("rb_rst.mem_addr", {228'd0, mem_data_addr}, {228'd0, Z28});
    chk("rb_rst.mem_wr", mem_data_wr, Z);
    chk("rb_rst.req1_ready", {255'd0, req1_ready}, {255'd0, 1'b0});
    chk("rb_rst.req0_rdata", req0_rdata, Z);
    chk("rb_rst.req1_rdata", req1_rdata, Z);
    chk("rb_rst.busy", {255'd0, busy}, {255'd0, 1'b0});
    chk("rb_rst.err", {255'd0, err_timeout}, {255'd0, 1'b0});
    idle_inputs();
    tick();
    chk("rb_post.req1_ready", {255'd0, req1_ready}, {255'd0, 1'b0});
    chk("rb_post.busy", {255'd0, busy}, {255'd0, 1'b0});
    chk("rb_post.mem_valid", {255'd0, mem_valid_data}, {255'd0, 1'b0});

    // mem_ready in the last allowed BUSY cycle beats the timeout.
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 28'h0000500; mem_data_rd = 256'hCAFE;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("pr_wait%0d.busy", i), {255'd0, busy}, {255'd0, 1'b1});
    end
    mem_ready_data = 1'b1;
    tick();
    chk("pr_fire.req0_ready", {255'd0, req0_ready}, {255'd0, 1'b1});
    chk("pr_fire.req0_rdata", req0_rdata, 256'hCAFE);
    chk("pr_fire.err", {255'd0, err_timeout}, {255'd0, 1'b0});
    chk("pr_fire.mem_valid", {255'd0, mem_valid_data}, {255'd0, 1'b0});
    req0_valid = 1'b0; mem_ready_data = 1'b0;
    tick();
    chk("pr_after.req0_ready", {255'd0, req0_ready}, {255'd0, 1'b0});
    chk("pr_after.err", {255'd0, err_timeout}, {255'd0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
